// File: rtl/su_rf_pkg.sv
// su_rf_pkg: shared widths, address type, one-hot helper and word-line constants for the scalar-unit register-file sequencer.
package su_rf_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;
  localparam logic [15:0] RF_W_IDLE_L  = 16'h0000;
  localparam logic [15:0] RF_W_IDLE_LB = 16'hFFFF;
  localparam logic [15:0] RF_W_IDLE_H  = 16'h0000;
  localparam logic [15:0] RF_W_IDLE_HB = 16'hFFFF;
  localparam logic [15:0] RF_R_R0_L    = 16'h0001;
  localparam logic [15:0] RF_R_R0_LB   = 16'hFFFE;
  localparam logic [15:0] RF_R_R0_H    = 16'h0000;
  localparam logic [15:0] RF_R_R0_HB   = 16'hFFFF;
  function automatic logic [31:0] rf_onehot(input rf_addr_t a);
    return 32'd1 << a;
  endfunction
endpackage

// File: rtl/su_rf_ctl_if.sv
// su_rf_ctl_if: register-file sequencer bus; forwarding signals exist only when SU_RF_FWD_EN is defined.
interface su_rf_ctl_if;
  import su_rf_pkg::*;
  logic rd_vld;
  rf_addr_t rs_addr, rt_addr;
  logic [15:0] INST_RAL, INST_RALB, INST_RAH, INST_RAHB;
  logic [15:0] INST_RBL, INST_RBLB, INST_RBH, INST_RBHB;
  logic [15:0] INST_WL, INST_WLB, INST_WH, INST_WHB;
  rf_data_t rf_d;
  logic alu_wb_vld;
  rf_addr_t alu_wb_addr;
  rf_data_t alu_wb_data;
  logic ld_ret_vld, ld_ret_rdy;
  rf_addr_t ld_ret_addr;
  rf_data_t ld_ret_data;
  logic iss_vld;
  rf_addr_t iss_rs, iss_rt, iss_rd;
  logic ld_issue;
  rf_addr_t ld_issue_addr;
  logic sb_stall;
`ifdef SU_RF_FWD_EN
  logic fwd_a, fwd_b;
  rf_data_t fwd_data;
`endif
  modport master (
    output rd_vld, rs_addr, rt_addr, alu_wb_vld, alu_wb_addr, alu_wb_data,
           ld_ret_vld, ld_ret_addr, ld_ret_data, iss_vld, iss_rs, iss_rt, iss_rd,
           ld_issue, ld_issue_addr,
    input  INST_RAL, INST_RALB, INST_RAH, INST_RAHB, INST_RBL, INST_RBLB, INST_RBH, INST_RBHB,
           INST_WL, INST_WLB, INST_WH, INST_WHB, rf_d, ld_ret_rdy, sb_stall
`ifdef SU_RF_FWD_EN
   ,input  fwd_a, fwd_b, fwd_data
`endif
  );
  modport slave (
    input  rd_vld, rs_addr, rt_addr, alu_wb_vld, alu_wb_addr, alu_wb_data,
           ld_ret_vld, ld_ret_addr, ld_ret_data, iss_vld, iss_rs, iss_rt, iss_rd,
           ld_issue, ld_issue_addr,
    output INST_RAL, INST_RALB, INST_RAH, INST_RAHB, INST_RBL, INST_RBLB, INST_RBH, INST_RBHB,
           INST_WL, INST_WLB, INST_WH, INST_WHB, rf_d, ld_ret_rdy, sb_stall
`ifdef SU_RF_FWD_EN
   ,output fwd_a, fwd_b, fwd_data
`endif
  );
endinterface

// File: rtl/su_rf_ldq.sv
// su_rf_ldq: load-return FIFO of {addr,data}; in_rdy is registered and low while full.
module su_rf_ldq
  import su_rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset_l,
  input  logic     in_vld,
  output logic     in_rdy,
  input  rf_addr_t in_addr,
  input  rf_data_t in_data,
  output logic     out_vld,
  input  logic     out_rdy,
  output rf_addr_t out_addr,
  output rf_data_t out_data
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic rdy_q, rdy_d, push, pop;
  rf_addr_t addr_q [DEPTH];
  rf_data_t data_q [DEPTH];
  always_comb begin
    push  = in_vld & rdy_q;
    pop   = out_rdy & (cnt_q != '0);
    wp_d  = wp_q + AW'(push);
    rp_d  = rp_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    rdy_d = cnt_d != (AW+1)'(DEPTH);
  end
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b1;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
    end
  always_ff @(posedge clk)
    if (push) begin
      addr_q[wp_q] <= in_addr;
      data_q[wp_q] <= in_data;
    end
  assign in_rdy   = rdy_q;
  assign out_vld  = cnt_q != '0;
  assign out_addr = addr_q[rp_q];
  assign out_data = data_q[rp_q];
endmodule

// File: rtl/su_rf_ctl.sv
// su_rf_ctl: 2R/1W register-file sequencer: dual-rail word-line encode, ALU/load write arbitration, load scoreboard.
// Define SU_RF_FWD_EN to add the registered write-to-read forwarding outputs.
module su_rf_ctl
  import su_rf_pkg::*;
#(
  parameter int LDQ_DEPTH = 2
) (
  input logic        clk,
  input logic        reset_l,
  su_rf_ctl_if.slave bus
);
  rf_addr_t ra_q, ra_d, rb_q, rb_d, w_addr_q, w_addr_d, q_addr;
  rf_data_t rf_d_q, rf_d_d, q_data;
  logic w_vld_q, w_vld_d, q_vld, q_pop;
  logic [31:0] pend_q, pend_d, ra_oh, rb_oh, w_oh;
  su_rf_ldq #(.DEPTH(LDQ_DEPTH)) u_ldq (
    .clk(clk), .reset_l(reset_l),
    .in_vld(bus.ld_ret_vld), .in_rdy(bus.ld_ret_rdy),
    .in_addr(bus.ld_ret_addr), .in_data(bus.ld_ret_data),
    .out_vld(q_vld), .out_rdy(q_pop), .out_addr(q_addr), .out_data(q_data)
  );
  // Any ALU writeback, even to r0, owns the write port for that cycle.
  always_comb begin
    q_pop    = !bus.alu_wb_vld;
    ra_d     = bus.rd_vld ? bus.rs_addr : ra_q;
    rb_d     = bus.rd_vld ? bus.rt_addr : rb_q;
    w_vld_d  = bus.alu_wb_vld ? (bus.alu_wb_addr != '0) : (q_vld && q_addr != '0);
    w_addr_d = bus.alu_wb_vld ? bus.alu_wb_addr : q_addr;
    rf_d_d   = !w_vld_d ? '0 : bus.alu_wb_vld ? bus.alu_wb_data : q_data;
    pend_d   = (pend_q & ~((q_pop && q_vld) ? rf_onehot(q_addr) : 32'd0))
             | (bus.ld_issue ? rf_onehot(bus.ld_issue_addr) : 32'd0);
    pend_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      ra_q     <= '0;
      rb_q     <= '0;
      w_vld_q  <= 1'b0;
      w_addr_q <= '0;
      rf_d_q   <= '0;
      pend_q   <= '0;
    end else begin
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      w_vld_q  <= w_vld_d;
      w_addr_q <= w_addr_d;
      rf_d_q   <= rf_d_d;
      pend_q   <= pend_d;
    end
  assign ra_oh          = rf_onehot(ra_q);
  assign rb_oh          = rf_onehot(rb_q);
  assign w_oh           = w_vld_q ? rf_onehot(w_addr_q) : {RF_W_IDLE_H, RF_W_IDLE_L};
  assign bus.INST_RAL   = ra_oh[15:0];
  assign bus.INST_RALB  = ~ra_oh[15:0];
  assign bus.INST_RAH   = ra_oh[31:16];
  assign bus.INST_RAHB  = ~ra_oh[31:16];
  assign bus.INST_RBL   = rb_oh[15:0];
  assign bus.INST_RBLB  = ~rb_oh[15:0];
  assign bus.INST_RBH   = rb_oh[31:16];
  assign bus.INST_RBHB  = ~rb_oh[31:16];
  assign bus.INST_WL    = w_oh[15:0];
  assign bus.INST_WLB   = ~w_oh[15:0];
  assign bus.INST_WH    = w_oh[31:16];
  assign bus.INST_WHB   = ~w_oh[31:16];
  assign bus.rf_d       = rf_d_q;
  assign bus.sb_stall   = (bus.iss_vld & (pend_q[bus.iss_rs] | pend_q[bus.iss_rt] | pend_q[bus.iss_rd]))
                        | (!bus.ld_ret_rdy & bus.alu_wb_vld);
`ifdef SU_RF_FWD_EN
  assign bus.fwd_a      = w_vld_q && (w_addr_q == ra_q);
  assign bus.fwd_b      = w_vld_q && (w_addr_q == rb_q);
  assign bus.fwd_data   = rf_d_q;
`endif
  always_ff @(posedge clk)
    if (reset_l && bus.ld_issue)
      assert (!bus.sb_stall && !pend_q[bus.ld_issue_addr])
        else $error("ERROR: su_rf_ctl ld_issue r%0d while stalled or already pending", bus.ld_issue_addr);
endmodule

// File: tb/tb_su_rf_ctl.sv
// tb_su_rf_ctl: directed vectors with hand-computed expectations for su_rf_ctl.
module tb_su_rf_ctl;
  logic clk = 1'b0;
  logic reset_l = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  su_rf_ctl_if bus ();
  su_rf_ctl #(.LDQ_DEPTH(2)) dut (.clk(clk), .reset_l(reset_l), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic alu(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.alu_wb_vld = v; bus.alu_wb_addr = a; bus.alu_wb_data = d;
  endtask
  task automatic ldr(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.ld_ret_vld = v; bus.ld_ret_addr = a; bus.ld_ret_data = d;
  endtask
  task automatic iss(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    bus.iss_vld = v; bus.iss_rs = rs; bus.iss_rt = rt; bus.iss_rd = rd;
  endtask
  initial begin
    bus.rd_vld = 0; bus.rs_addr = 0; bus.rt_addr = 0;
    alu(0, 0, 0); ldr(0, 0, 0); iss(0, 0, 0, 0);
    bus.ld_issue = 0; bus.ld_issue_addr = 0;
    repeat (2) step();
    chk("rst_ral", 32'(bus.INST_RAL), 32'h0001);
    chk("rst_ralb", 32'(bus.INST_RALB), 32'hFFFE);
    chk("rst_rahb", 32'(bus.INST_RAHB), 32'hFFFF);
    chk("rst_rbl", 32'(bus.INST_RBL), 32'h0001);
    chk("rst_wl", 32'(bus.INST_WL), 32'h0000);
    chk("rst_wlb", 32'(bus.INST_WLB), 32'hFFFF);
    chk("rst_whb", 32'(bus.INST_WHB), 32'hFFFF);
    chk("rst_rf_d", bus.rf_d, 32'h0);
    chk("rst_rdy", 32'(bus.ld_ret_rdy), 32'h1);
    reset_l = 1;
    // read encode rs=5 rt=20
    bus.rd_vld = 1; bus.rs_addr = 5; bus.rt_addr = 20;
    step();
    bus.rd_vld = 0; bus.rs_addr = 1; bus.rt_addr = 1;
    chk("rd_ral", 32'(bus.INST_RAL), 32'h0020);
    chk("rd_ralb", 32'(bus.INST_RALB), 32'hFFDF);
    chk("rd_rah", 32'(bus.INST_RAH), 32'h0000);
    chk("rd_rahb", 32'(bus.INST_RAHB), 32'hFFFF);
    chk("rd_rbh", 32'(bus.INST_RBH), 32'h0010);
    chk("rd_rbhb", 32'(bus.INST_RBHB), 32'hFFEF);
    chk("rd_rbl", 32'(bus.INST_RBL), 32'h0000);
    step();
    chk("rd_hold", 32'(bus.INST_RAL), 32'h0020);
    // ALU r3 and load r7 together
    alu(1, 3, 32'hDEADBEEF); ldr(1, 7, 32'h12345678);
    step();
    alu(0, 0, 0); ldr(0, 0, 0);
    chk("arb_wl1", 32'(bus.INST_WL), 32'h0008);
    chk("arb_wlb1", 32'(bus.INST_WLB), 32'hFFF7);
    chk("arb_d1", bus.rf_d, 32'hDEADBEEF);
    step();
    chk("arb_wl2", 32'(bus.INST_WL), 32'h0080);
    chk("arb_d2", bus.rf_d, 32'h12345678);
    step();
    chk("arb_idle", 32'(bus.INST_WL), 32'h0000);
    // scoreboard on r9
    bus.ld_issue = 1; bus.ld_issue_addr = 9;
    step();
    bus.ld_issue = 0;
    iss(1, 9, 1, 2);
    #1 chk("sb_set", 32'(bus.sb_stall), 32'h1);
    ldr(1, 9, 32'h000000AA);
    step();
    ldr(0, 0, 0);
    chk("sb_queued", 32'(bus.sb_stall), 32'h1);
    step();
    chk("sb_clr", 32'(bus.sb_stall), 32'h0);
    chk("sb_wl", 32'(bus.INST_WL), 32'h0200);
    chk("sb_d", bus.rf_d, 32'h000000AA);
    iss(0, 0, 0, 0);
    // ALU busy four cycles, three loads
    alu(1, 1, 32'h1); ldr(1, 10, 32'hA0);
    step();
    chk("q_wl_alu1", 32'(bus.INST_WL), 32'h0002);
    alu(1, 2, 32'h2); ldr(1, 11, 32'hA1);
    step();
    chk("q_rdy_full", 32'(bus.ld_ret_rdy), 32'h0);
    alu(1, 3, 32'h3); ldr(1, 12, 32'hA2); iss(1, 0, 0, 0);
    #1 chk("q_stall_full", 32'(bus.sb_stall), 32'h1);
    step();
    iss(0, 0, 0, 0);
    alu(1, 4, 32'h4);
    step();
    chk("q_d_alu4", bus.rf_d, 32'h4);
    chk("q_rdy_still", 32'(bus.ld_ret_rdy), 32'h0);
    alu(0, 0, 0);
    step();
    chk("q_wl_l10", 32'(bus.INST_WL), 32'h0400);
    chk("q_d_l10", bus.rf_d, 32'hA0);
    chk("q_rdy_back", 32'(bus.ld_ret_rdy), 32'h1);
    step();
    ldr(0, 0, 0);
    chk("q_wl_l11", 32'(bus.INST_WL), 32'h0800);
    chk("q_d_l11", bus.rf_d, 32'hA1);
    step();
    chk("q_wl_l12", 32'(bus.INST_WL), 32'h1000);
    chk("q_d_l12", bus.rf_d, 32'hA2);
    step();
    // r0 writes with pend[9] set
    bus.ld_issue = 1; bus.ld_issue_addr = 9;
    step();
    bus.ld_issue = 0;
    alu(1, 0, 32'h55); ldr(1, 0, 32'h66);
    step();
    alu(0, 0, 0); ldr(0, 0, 0);
    chk("r0_wl1", 32'(bus.INST_WL), 32'h0000);
    chk("r0_wlb1", 32'(bus.INST_WLB), 32'hFFFF);
    chk("r0_wh1", 32'(bus.INST_WH), 32'h0000);
    step();
    chk("r0_wl2", 32'(bus.INST_WL), 32'h0000);
    chk("r0_whb2", 32'(bus.INST_WHB), 32'hFFFF);
    iss(1, 9, 0, 0);
    #1 chk("r0_pend", 32'(bus.sb_stall), 32'h1);
    iss(0, 0, 0, 0);
    // async reset mid-operation
    alu(1, 1, 32'h11); ldr(1, 5, 32'hB5);
    step();
    alu(1, 2, 32'h22); ldr(1, 6, 32'hB6);
    step();
    chk("ar_rdy_pre", 32'(bus.ld_ret_rdy), 32'h0);
    chk("ar_wl_pre", 32'(bus.INST_WL), 32'h0004);
    alu(0, 0, 0); ldr(0, 0, 0); iss(1, 9, 0, 0);
    reset_l = 0;
    #1;
    chk("ar_wl", 32'(bus.INST_WL), 32'h0000);
    chk("ar_wlb", 32'(bus.INST_WLB), 32'hFFFF);
    chk("ar_rf_d", bus.rf_d, 32'h0);
    chk("ar_rdy", 32'(bus.ld_ret_rdy), 32'h1);
    chk("ar_pend", 32'(bus.sb_stall), 32'h0);
    chk("ar_ral", 32'(bus.INST_RAL), 32'h0001);
    step();
    reset_l = 1; iss(0, 0, 0, 0);
    step();
    chk("ar_drop1", 32'(bus.INST_WL), 32'h0000);
    step();
    chk("ar_drop2", 32'(bus.INST_WL), 32'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
